core_in_buffer: RTL and testbench

// - Ping-pong pixel input buffer between the AHB read master and the rotation core.
// - AHB side writes one 32-bit beat per cycle; each byte lane carries its own byte address.
// - Core side reads one pixel per cycle as three independent byte reads (R, G, B).
// - Each bank holds one 8x8 RGB tile: 64 pixels x 3 bytes = 192 bytes. One bank fills while the other drains.

---
 rtl/core_in_buffer_pkg.sv | 26 ++
 rtl/core_in_buffer_if.sv | 42 ++++
 rtl/core_ib_bank.sv | 54 +++++
 rtl/core_in_buffer.sv | 139 +++++++++++++
 tb/tb_core_in_buffer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_in_buffer_pkg.sv
// Purpose : shared sizes, bank-state codes and the address range check for the ping-pong input buffer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package core_in_buffer_pkg;

  localparam int P_AW     = 8;            // byte address width
  localparam int P_DEPTH  = 192;          // bytes per bank (8x8 RGB tile)
  localparam int P_WORDS  = P_DEPTH / 4;  // 32-bit write beats per bank fill
  localparam int P_PIXELS = 64;           // pixel reads per bank drain

  localparam logic [P_AW-1:0] P_DEPTH_A = P_AW'(P_DEPTH);

  // Bit 1 set means the bank holds a complete tile (FULL or DRAINING),
  // so the ready flags fall straight out of the encoding.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'b00,
    BANK_FILLING  = 2'b01,
    BANK_FULL     = 2'b10,
    BANK_DRAINING = 2'b11
  } bank_st_t;

  function automatic logic addr_ok(input logic [P_AW-1:0] a);
    return a < P_DEPTH_A;
  endfunction

endpackage

// File: rtl/core_in_buffer_if.sv
// Purpose : write-beat, pixel-read and status signals between the AHB master, the core and the buffer.
// Latency : n/a (wiring only).
// Backpressure: O_IB_WR_READY gates writes, O_IB_RD_READY gates reads.
// Modports: master = AHB/core side (drives I_*), slave = buffer (drives O_*).
interface core_in_buffer_if;
  import core_in_buffer_pkg::*;

  logic            I_IB_WR_EN;
  logic [P_AW-1:0] I_IB_WR_ADDR0;
  logic [P_AW-1:0] I_IB_WR_ADDR1;
  logic [P_AW-1:0] I_IB_WR_ADDR2;
  logic [P_AW-1:0] I_IB_WR_ADDR3;
  logic [31:0]     I_IB_WR_DATA;
  logic            O_IB_WR_READY;
  logic            I_IB_RD_EN;
  logic [P_AW-1:0] I_IB_RD_ADDRR;
  logic [P_AW-1:0] I_IB_RD_ADDRG;
  logic [P_AW-1:0] I_IB_RD_ADDRB;
  logic [7:0]      O_IB_RD_R;
  logic [7:0]      O_IB_RD_G;
  logic [7:0]      O_IB_RD_B;
  logic            O_IB_RD_VALID;
  logic            O_IB_RD_READY;
  logic [1:0]      O_IB_BANK_FULL;
  logic            O_IB_OVERFLOW;
  logic            O_IB_ADDR_ERR;

  modport master (
    output I_IB_WR_EN, I_IB_WR_ADDR0, I_IB_WR_ADDR1, I_IB_WR_ADDR2, I_IB_WR_ADDR3,
    output I_IB_WR_DATA, I_IB_RD_EN, I_IB_RD_ADDRR, I_IB_RD_ADDRG, I_IB_RD_ADDRB,
    input  O_IB_WR_READY, O_IB_RD_R, O_IB_RD_G, O_IB_RD_B, O_IB_RD_VALID,
    input  O_IB_RD_READY, O_IB_BANK_FULL, O_IB_OVERFLOW, O_IB_ADDR_ERR
  );

  modport slave (
    input  I_IB_WR_EN, I_IB_WR_ADDR0, I_IB_WR_ADDR1, I_IB_WR_ADDR2, I_IB_WR_ADDR3,
    input  I_IB_WR_DATA, I_IB_RD_EN, I_IB_RD_ADDRR, I_IB_RD_ADDRG, I_IB_RD_ADDRB,
    output O_IB_WR_READY, O_IB_RD_R, O_IB_RD_G, O_IB_RD_B, O_IB_RD_VALID,
    output O_IB_RD_READY, O_IB_BANK_FULL, O_IB_OVERFLOW, O_IB_ADDR_ERR
  );

endinterface

// File: rtl/core_ib_bank.sv
// Purpose : one 192x8 tile bank, 4 byte write lanes, 3 registered byte read ports, range checks.
// Latency : write lands on the enabling edge; read data registered 1 cycle after rd_en.
// Backpressure: none here; the top only enables a bank it owns. Read regs hold when rd_en is low.
// Ports: clk/rst, wr_en + wr_addr[4] + wr_dat, rd_en + rd_addr[3] -> rd_dat[3], wr_err/rd_err (comb).
module core_ib_bank
  import core_in_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [3:0][P_AW-1:0] wr_addr,
  input  logic [31:0]          wr_dat,
  input  logic                 rd_en,
  input  logic [2:0][P_AW-1:0] rd_addr,
  output logic [2:0][7:0]      rd_dat,
  output logic                 wr_err,
  output logic                 rd_err
);

  logic [7:0] mem [P_DEPTH];

  // Lanes are written in ascending order, so on a duplicate address the
  // last (highest) lane's non-blocking write is the one that sticks.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (addr_ok(wr_addr[n])) mem[wr_addr[n]] <= wr_dat[8*n +: 8];
      end
    end
  end

  // Out-of-range read bytes return zero rather than whatever mem[] aliases to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      for (int c = 0; c < 3; c++) begin
        rd_dat[c] <= addr_ok(rd_addr[c]) ? mem[rd_addr[c]] : 8'h00;
      end
    end
  end

  always_comb begin
    wr_err = 1'b0;
    rd_err = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (wr_en && !addr_ok(wr_addr[n])) wr_err = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      if (rd_en && !addr_ok(rd_addr[c])) rd_err = 1'b1;
    end
  end

endmodule

// File: rtl/core_in_buffer.sv
// Purpose : ping-pong tile buffer; one bank fills from AHB beats while the other drains pixels to the core.
// Latency : write lands on the accepting edge; pixel data and RD_VALID 1 cycle after an accepted read.
// Backpressure: WR_READY low when the write bank is full (beat dropped, OVERFLOW set); RD_READY low until a whole tile is in.
// Ports: I_IB_HCLK, I_IB_RESET (sync, active-high), ib (slave modport: write beat, pixel read, status flags).
module core_in_buffer
  import core_in_buffer_pkg::*;
(
  input logic             I_IB_HCLK,
  input logic             I_IB_RESET,
  core_in_buffer_if.slave ib
);

  localparam logic [5:0] WR_LAST = 6'(P_WORDS - 1);
  localparam logic [6:0] RD_LAST = 7'(P_PIXELS - 1);

  bank_st_t   st_q [2];
  bank_st_t   st_d [2];
  logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic       rd_bank_q, rd_bank_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [6:0] rd_cnt_q, rd_cnt_d;
  logic       rd_vld_q, rd_vld_d, ovf_q, ovf_d, aerr_q, aerr_d;

  logic                 wr_ready, rd_ready, wr_acc, rd_acc;
  logic [3:0][P_AW-1:0] wr_addr;
  logic [2:0][P_AW-1:0] rd_addr;
  logic [1:0]           bank_wr_en, bank_rd_en, bank_wr_err, bank_rd_err;
  logic [2:0][7:0]      bank_rd [2];

  assign wr_addr = {ib.I_IB_WR_ADDR3, ib.I_IB_WR_ADDR2, ib.I_IB_WR_ADDR1, ib.I_IB_WR_ADDR0};
  assign rd_addr = {ib.I_IB_RD_ADDRB, ib.I_IB_RD_ADDRG, ib.I_IB_RD_ADDRR};

  // Ready flags come from registered state only; a bank released on an
  // edge becomes usable by the other side from the following cycle.
  assign wr_ready = (st_q[wr_sel_q] == BANK_EMPTY) || (st_q[wr_sel_q] == BANK_FILLING);
  assign rd_ready = (st_q[rd_sel_q] == BANK_FULL)  || (st_q[rd_sel_q] == BANK_DRAINING);
  assign wr_acc   = ib.I_IB_WR_EN & wr_ready;
  assign rd_acc   = ib.I_IB_RD_EN & rd_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = wr_acc && (wr_sel_q == 1'(b));
    assign bank_rd_en[b] = rd_acc && (rd_sel_q == 1'(b));

    core_ib_bank u_bank (
      .clk     (I_IB_HCLK),
      .rst     (I_IB_RESET),
      .wr_en   (bank_wr_en[b]),
      .wr_addr (wr_addr),
      .wr_dat  (ib.I_IB_WR_DATA),
      .rd_en   (bank_rd_en[b]),
      .rd_addr (rd_addr),
      .rd_dat  (bank_rd[b]),
      .wr_err  (bank_wr_err[b]),
      .rd_err  (bank_rd_err[b])
    );
  end

  always_ff @(posedge I_IB_HCLK) begin
    if (I_IB_RESET) begin
      st_q[0]   <= BANK_EMPTY;
      st_q[1]   <= BANK_EMPTY;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      aerr_q    <= 1'b0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      ovf_q     <= ovf_d;
      aerr_q    <= aerr_d;
    end
  end

  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_vld_d  = rd_acc;
    // Remember which bank served the read so the output mux stays on it
    // even after rd_sel flips at the end of a drain.
    rd_bank_d = rd_acc ? rd_sel_q : rd_bank_q;
    ovf_d     = ovf_q | (ib.I_IB_WR_EN & ~wr_ready);
    aerr_d    = aerr_q | (|bank_wr_err) | (|bank_rd_err);

    if (wr_acc) begin
      if (wr_cnt_q == WR_LAST) begin
        wr_cnt_d = '0;
        wr_sel_d = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 6'd1;
      end
    end

    if (rd_acc) begin
      if (rd_cnt_q == RD_LAST) begin
        rd_cnt_d = '0;
        rd_sel_d = ~rd_sel_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 7'd1;
      end
    end

    // Fill and drain never own the same bank, so both updates can apply.
    for (int b = 0; b < 2; b++) begin
      if (bank_wr_en[b]) begin
        if (wr_cnt_q == WR_LAST) st_d[b] = BANK_FULL;
        else                     st_d[b] = BANK_FILLING;
      end
      if (bank_rd_en[b]) begin
        if (rd_cnt_q == RD_LAST) st_d[b] = BANK_EMPTY;
        else                     st_d[b] = BANK_DRAINING;
      end
    end
  end

  assign ib.O_IB_WR_READY  = wr_ready;
  assign ib.O_IB_RD_READY  = rd_ready;
  assign ib.O_IB_RD_VALID  = rd_vld_q;
  assign ib.O_IB_RD_R      = bank_rd[rd_bank_q][0];
  assign ib.O_IB_RD_G      = bank_rd[rd_bank_q][1];
  assign ib.O_IB_RD_B      = bank_rd[rd_bank_q][2];
  assign ib.O_IB_BANK_FULL = {st_q[1][1], st_q[0][1]};
  assign ib.O_IB_OVERFLOW  = ovf_q;
  assign ib.O_IB_ADDR_ERR  = aerr_q;

endmodule

// File: tb/tb_core_in_buffer.sv
// Purpose : directed bench for core_in_buffer: reset, fill/drain, overlap, overflow, range errors, mid-fill reset.
// Latency : checks sample #1 after each rising edge, i.e. the state registered by that edge.
// Backpressure: exercised by writing into two full banks and reading from an empty buffer.
module tb_core_in_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_in_buffer_if ib ();

  core_in_buffer dut (
    .I_IB_HCLK  (clk),
    .I_IB_RESET (rst),
    .ib         (ib.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic [7:0] ar, ag, ab;
    logic       ev;
    logic [7:0] er, eg, eb;
  } rd_vec_t;

  rd_vec_t tv [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: data = addr, 1: ~addr, 2: addr^5A, 3: addr^A5
  function automatic logic [7:0] pat(input logic [7:0] a, input int mode);
    case (mode)
      0:       return a;
      1:       return ~a;
      2:       return a ^ 8'h5A;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] status();
    return {28'd0, ib.O_IB_WR_READY, ib.O_IB_RD_READY, ib.O_IB_BANK_FULL};
  endfunction

  function automatic logic [31:0] pix();
    return {7'd0, ib.O_IB_RD_VALID, ib.O_IB_RD_R, ib.O_IB_RD_G, ib.O_IB_RD_B};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [7:0] a0, a1, a2, a3, input logic [31:0] d);
    ib.I_IB_WR_EN    = en;
    ib.I_IB_WR_ADDR0 = a0;
    ib.I_IB_WR_ADDR1 = a1;
    ib.I_IB_WR_ADDR2 = a2;
    ib.I_IB_WR_ADDR3 = a3;
    ib.I_IB_WR_DATA  = d;
  endtask

  task automatic set_rd(input logic en, input logic [7:0] r, g, b);
    ib.I_IB_RD_EN    = en;
    ib.I_IB_RD_ADDRR = r;
    ib.I_IB_RD_ADDRG = g;
    ib.I_IB_RD_ADDRB = b;
  endtask

  task automatic std_beat(input int k, input int mode);
    logic [7:0] a0, a1, a2, a3;
    a0 = 8'(4*k);
    a1 = 8'(4*k + 1);
    a2 = 8'(4*k + 2);
    a3 = 8'(4*k + 3);
    set_wr(1'b1, a0, a1, a2, a3, {pat(a3, mode), pat(a2, mode), pat(a1, mode), pat(a0, mode)});
  endtask

  task automatic fill(input int k0, input int k1, input int mode);
    for (int k = k0; k < k1; k++) begin
      std_beat(k, mode);
      tick();
    end
    set_wr(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
  endtask

  task automatic std_read(input int p);
    set_rd(1'b1, 8'(3*p), 8'(3*p + 1), 8'(3*p + 2));
  endtask

  task automatic chk_pix(input string name, input int p, input int mode);
    chk(name, pix(), {7'd0, 1'b1, pat(8'(3*p), mode), pat(8'(3*p + 1), mode), pat(8'(3*p + 2), mode)});
  endtask

  task automatic drain(input int p0, input int p1, input int mode, input string name);
    for (int p = p0; p < p1; p++) begin
      std_read(p);
      tick();
      chk_pix(name, p, mode);
    end
    set_rd(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bank1 reads after the overlap fill (data = ~addr); last entry is an idle cycle.
    tv[0] = '{1'b1, 8'd0,   8'd1,  8'd2,   1'b1, 8'hFF, 8'hFE, 8'hFD};
    tv[1] = '{1'b1, 8'd191, 8'd190, 8'd189, 1'b1, 8'h40, 8'h41, 8'h42};
    tv[2] = '{1'b1, 8'd100, 8'd50, 8'd25,  1'b1, 8'h9B, 8'hCD, 8'hE6};
    tv[3] = '{1'b1, 8'd3,   8'd3,  8'd3,   1'b1, 8'hFC, 8'hFC, 8'hFC};
    tv[4] = '{1'b1, 8'd128, 8'd64, 8'd32,  1'b1, 8'h7F, 8'hBF, 8'hDF};
    tv[5] = '{1'b1, 8'd7,   8'd8,  8'd9,   1'b1, 8'hF8, 8'hF7, 8'hF6};
    tv[6] = '{1'b1, 8'd170, 8'd85, 8'd0,   1'b1, 8'h55, 8'hAA, 8'hFF};
    tv[7] = '{1'b1, 8'd190, 8'd2,  8'd188, 1'b1, 8'h41, 8'hFD, 8'h43};
    tv[8] = '{1'b0, 8'd10,  8'd11, 8'd12,  1'b0, 8'h41, 8'hFD, 8'h43};

    set_wr(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
    set_rd(1'b0, 8'h00, 8'h00, 8'h00);

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_status", status(), 32'h8);
    chk("reset_data", pix(), 32'h0);
    chk("reset_flags", {30'd0, ib.O_IB_OVERFLOW, ib.O_IB_ADDR_ERR}, 32'h0);

    // Fill bank0 with data = address; tile completes only on beat 48
    fill(0, 47, 0);
    chk("fill0_47", status(), 32'h8);
    fill(47, 48, 0);
    chk("fill0_48", status(), 32'hD);

    // Drain bank0 while filling bank1 with ~address
    for (int p = 0; p < 64; p++) begin
      std_read(p);
      if (p < 48) std_beat(p, 1);
      else        set_wr(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
      tick();
      chk_pix("overlap_rd0", p, 0);
      if (p == 47) chk("overlap_b1_full", status(), 32'h7);
      if (p == 62) chk("overlap_63rd", status(), 32'h7);
    end
    set_rd(1'b0, 8'h00, 8'h00, 8'h00);
    chk("overlap_done", status(), 32'hE);

    // Bank1 readback: table vectors, then the rest of the drain
    for (int i = 0; i < 9; i++) begin
      set_rd(tv[i].en, tv[i].ar, tv[i].ag, tv[i].ab);
      tick();
      chk($sformatf("tbl_%0d", i), pix(), {7'd0, tv[i].ev, tv[i].er, tv[i].eg, tv[i].eb});
    end
    drain(8, 64, 1, "drain_b1");
    chk("b1_empty", status(), 32'h8);
    set_rd(1'b1, 8'd0, 8'd1, 8'd2);
    tick();
    set_rd(1'b0, 8'h00, 8'h00, 8'h00);
    chk("rd_not_ready_hold", pix(), {7'd0, 1'b0, 8'h42, 8'h41, 8'h40});

    // Both banks full, then a dropped beat
    fill(0, 48, 2);
    fill(0, 48, 3);
    chk("both_full", status(), 32'h7);
    chk("ovf_before", {31'd0, ib.O_IB_OVERFLOW}, 32'h0);
    set_wr(1'b1, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFFFF_FFFF);
    tick();
    set_wr(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
    chk("ovf_set", {31'd0, ib.O_IB_OVERFLOW}, 32'h1);
    chk("ovf_status", status(), 32'h7);
    drain(0, 63, 2, "drain_b0_ovf");
    chk("no_bypass", status(), 32'h7);
    drain(63, 64, 2, "drain_b0_ovf");
    chk("b0_released", status(), 32'hE);

    // Out-of-range lane/read and duplicate lane addresses
    chk("aerr_before", {31'd0, ib.O_IB_ADDR_ERR}, 32'h0);
    set_wr(1'b1, 8'hC0, 8'd1, 8'd2, 8'd3, 32'h3322_11EE);
    tick();
    chk("aerr_wr", {31'd0, ib.O_IB_ADDR_ERR}, 32'h1);
    set_wr(1'b1, 8'd4, 8'd4, 8'd6, 8'd7, 32'h0706_4499);
    tick();
    fill(2, 48, 0);
    chk("aerr_fill", status(), 32'h7);
    set_rd(1'b1, 8'hC0, 8'd0, 8'd1);
    tick();
    chk("rd_c0_b1", pix(), {7'd0, 1'b1, 8'h00, 8'hA5, 8'hA4});
    drain(1, 64, 3, "drain_b1_a5");
    chk("b1_drained", status(), 32'hD);
    set_rd(1'b1, 8'hC0, 8'd1, 8'd2);
    tick();
    chk("rd_c0_b0", pix(), {7'd0, 1'b1, 8'h00, 8'h11, 8'h22});
    set_rd(1'b1, 8'd3, 8'd4, 8'd5);
    tick();
    chk("dup_lane", pix(), {7'd0, 1'b1, 8'h33, 8'h44, 8'h5F});
    drain(2, 64, 0, "drain_b0_aerr");
    chk("all_empty", status(), 32'h8);
    chk("sticky_flags", {30'd0, ib.O_IB_OVERFLOW, ib.O_IB_ADDR_ERR}, 32'h3);

    // Reset in the middle of a fill
    fill(0, 20, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst2_status", status(), 32'h8);
    chk("rst2_flags", {30'd0, ib.O_IB_OVERFLOW, ib.O_IB_ADDR_ERR}, 32'h0);
    chk("rst2_data", pix(), 32'h0);
    fill(0, 47, 0);
    chk("rst2_fill47", status(), 32'h8);
    fill(47, 48, 0);
    chk("rst2_fill48", status(), 32'hD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
